// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the MAC sequencer.
// Holds the FSM state enum, datapath widths and the default buffer depth.
package mac_seq_pkg;

  localparam int W_OP      = 8;
  localparam int W_RES     = 17;
  localparam int W_CNT     = 4;
  localparam int N_MAX_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  function automatic logic [W_CNT-1:0] clamp_count(
    input logic [W_CNT-1:0] c,
    input int               n
  );
    return (int'(c) > n) ? W_CNT'(n) : c;
  endfunction

endpackage

// File: rtl/mac_seq_opbuf.sv
// Operand buffer: N_MAX x 2W register file with write pointer,
// read index and the Horner x latch taken from the first beat.
module mac_seq_opbuf
  import mac_seq_pkg::*;
#(
  parameter int N_MAX = N_MAX_DEF,
  parameter int W     = W_OP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [W-1:0]     wr_a,
  input  logic [W-1:0]     wr_b,
  input  logic             rd_inc,
  output logic [W_CNT-1:0] wr_ptr,
  output logic [W_CNT-1:0] rd_idx,
  output logic [W-1:0]     rd_a,
  output logic [W-1:0]     rd_b,
  output logic [W-1:0]     x
);

  localparam int AW = (N_MAX > 1) ? $clog2(N_MAX) : 1;

  logic [W-1:0] a_mem [N_MAX];
  logic [W-1:0] b_mem [N_MAX];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_idx <= '0;
      x      <= '0;
      for (int i = 0; i < N_MAX; i++) begin
        a_mem[i] <= '0;
        b_mem[i] <= '0;
      end
    end else if (clr) begin
      wr_ptr <= '0;
      rd_idx <= '0;
    end else begin
      if (wr_en) begin
        a_mem[wr_ptr[AW-1:0]] <= wr_a;
        b_mem[wr_ptr[AW-1:0]] <= wr_b;
        wr_ptr <= wr_ptr + W_CNT'(1);
        if (wr_ptr == '0)
          x <= wr_b;
      end
      if (rd_inc)
        rd_idx <= rd_idx + W_CNT'(1);
    end
  end

  assign rd_a = a_mem[rd_idx[AW-1:0]];
  assign rd_b = b_mem[rd_idx[AW-1:0]];

endmodule

// File: rtl/mac_sequencer.sv
// Sequencer driving the two-cycle MAC datapath for SOP and Horner jobs.
// Optional sticky overflow output res_ovf is enabled by MAC_SEQ_OVF_EN.
module mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int N_MAX = N_MAX_DEF,
  parameter int W     = W_OP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [W_CNT-1:0] count,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [W-1:0]     op_a,
  input  logic [W-1:0]     op_b,
  output logic [W-1:0]     mac_in_1,
  output logic [W-1:0]     mac_in_2,
  output logic [W-1:0]     mac_in_add,
  output logic             mac_mul_sel,
  output logic             mac_add_sel,
  output logic             mac_mode,
  input  logic [W_RES-1:0] mac_result,
  output logic             busy,
  output logic             res_valid,
  output logic [W_RES-1:0] res_data
`ifdef MAC_SEQ_OVF_EN
  ,
  output logic             res_ovf
`endif
);

  state_t state, state_n;

  logic [W_CNT-1:0] cnt_q;
  logic             mode_q;
  logic             accept;
  logic             op_fire;
  logic             last_beat;
  logic             last_step;
  logic             first_step;
  logic             rd_inc;
  logic [W_CNT-1:0] wr_ptr;
  logic [W_CNT-1:0] rd_idx;
  logic [W-1:0]     buf_a;
  logic [W-1:0]     buf_b;
  logic [W-1:0]     buf_x;

  assign accept     = (state == S_IDLE) && start;
  assign op_fire    = op_valid && op_ready;
  assign last_beat  = (wr_ptr == cnt_q - W_CNT'(1));
  assign last_step  = (rd_idx == cnt_q - W_CNT'(1));
  assign first_step = (rd_idx == '0);
  assign rd_inc     = (state == S_WAIT) && !last_step;

  mac_seq_opbuf #(
    .N_MAX (N_MAX),
    .W     (W)
  ) u_opbuf (
    .clk    (clk),
    .reset  (reset),
    .clr    (accept),
    .wr_en  (op_fire),
    .wr_a   (op_a),
    .wr_b   (op_b),
    .rd_inc (rd_inc),
    .wr_ptr (wr_ptr),
    .rd_idx (rd_idx),
    .rd_a   (buf_a),
    .rd_b   (buf_b),
    .x      (buf_x)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  // An empty job still passes through CAPTURE so its strobe lands
  // two cycles after start, matching the 3n+2 job timeline.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (start)
          state_n = (count == '0) ? S_CAPTURE : S_LOAD;
      S_LOAD:
        if (op_fire && last_beat)
          state_n = S_ISSUE;
      S_ISSUE:
        state_n = S_WAIT;
      S_WAIT:
        state_n = last_step ? S_CAPTURE : S_ISSUE;
      S_CAPTURE:
        state_n = S_DONE;
      S_DONE:
        state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
  end

  always_comb begin
    mac_in_1    = '0;
    mac_in_2    = '0;
    mac_in_add  = '0;
    mac_mul_sel = 1'b0;
    mac_add_sel = 1'b0;
    busy        = (state != S_IDLE);
    op_ready    = (state == S_LOAD);
    res_valid   = (state == S_DONE);
    mac_mode    = busy && mode_q;
    if (state == S_ISSUE) begin
      unique case (1'b1)
        mode_q: begin
          mac_in_2    = buf_x;
          mac_in_add  = buf_a;
          mac_mul_sel = !first_step;
        end
        !mode_q: begin
          mac_in_1    = buf_a;
          mac_in_2    = buf_b;
          mac_add_sel = !first_step;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      res_data <= '0;
    end else begin
      if (accept) begin
        cnt_q  <= clamp_count(count, N_MAX);
        mode_q <= mode;
      end
      if (state == S_CAPTURE)
        res_data <= (cnt_q == '0) ? '0 : mac_result;
    end
  end

`ifdef MAC_SEQ_OVF_EN
  logic ovf_sticky;

  // Step 0 and 1 feedback cannot exceed 16 bits, so watch from k = 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_sticky <= 1'b0;
      res_ovf    <= 1'b0;
    end else begin
      if (accept)
        ovf_sticky <= 1'b0;
      else if (state == S_ISSUE && rd_idx >= W_CNT'(2) && mac_result[W_RES-1])
        ovf_sticky <= 1'b1;
      if (state == S_CAPTURE)
        res_ovf <= (cnt_q != '0) && (ovf_sticky || mac_result[W_RES-1]);
    end
  end
`endif

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer with a behavioural MAC datapath.
// Builds with or without MAC_SEQ_OVF_EN.
module tb_mac_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [3:0]  count = '0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [7:0]  op_a = '0;
  logic [7:0]  op_b = '0;
  logic [7:0]  mac_in_1, mac_in_2, mac_in_add;
  logic        mac_mul_sel, mac_add_sel, mac_mode;
  logic [16:0] mac_result;
  logic        busy, res_valid;
  logic [16:0] res_data;
`ifdef MAC_SEQ_OVF_EN
  logic        res_ovf;
`endif

  typedef struct {
    logic [16:0] data;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  logic [7:0] beat_a [16];
  logic [7:0] beat_b [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_sequencer #(.N_MAX(8), .W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .count       (count),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .mac_in_1    (mac_in_1),
    .mac_in_2    (mac_in_2),
    .mac_in_add  (mac_in_add),
    .mac_mul_sel (mac_mul_sel),
    .mac_add_sel (mac_add_sel),
    .mac_mode    (mac_mode),
    .mac_result  (mac_result),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_data    (res_data)
`ifdef MAC_SEQ_OVF_EN
    ,
    .res_ovf     (res_ovf)
`endif
  );

  // Datapath: multiply/addend register, then adder register.
  logic [15:0] prod_r;
  logic [16:0] add_r, acc;
  logic [16:0] m1;
  logic [33:0] full;
  assign mac_result = acc;
  assign m1   = mac_mul_sel ? acc : {9'd0, mac_in_1};
  assign full = {17'd0, m1} * {26'd0, mac_in_2};

  always @(posedge clk) begin
    if (reset) begin
      prod_r <= '0;
      add_r  <= '0;
      acc    <= '0;
    end else begin
      prod_r <= full[15:0];
      add_r  <= mac_add_sel ? acc : {9'd0, mac_in_add};
      acc    <= {1'b0, prod_r} + add_r;
    end
  end

  function automatic logic [26:0] mac_all();
    return {mac_in_1, mac_in_2, mac_in_add,
            mac_mul_sel, mac_add_sel, mac_mode};
  endfunction

  task automatic run_job(input bit md, input logic [3:0] cnt,
                         input int nb, input int gap,
                         input logic [16:0] ed, input bit eo,
                         input int eoff, input string nm);
    exp_t e;
    int   t0, w;
    bit   got, bad_ready, bad_mac;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0)
      $display("FAIL %s idle_at_start: busy=%0b need 0", nm, busy);
    else n_pass++;
    start = 1'b1; mode = md; count = cnt; t0 = cyc;
    e.data = ed; e.ovf = eo; e.cyc = (eoff < 0) ? -1 : t0 + eoff;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; count = '0;
    bad_ready = 1'b0; bad_mac = 1'b0;
    for (int i = 0; i < nb; i++) begin
      op_valid = 1'b1; op_a = beat_a[i]; op_b = beat_b[i];
      w = 0;
      while (op_ready !== 1'b1 && w < 50) begin
        @(negedge clk); w++;
      end
      if (w >= 50) begin
        n_checks++;
        $display("FAIL %s load_timeout: beat %0d never accepted", nm, i);
      end
      @(negedge clk);
      op_valid = 1'b0;
      if (i < nb - 1)
        for (int g = 0; g < gap; g++) begin
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
    end
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (op_ready === 1'b1) bad_ready = 1'b1;
      if (cnt == 0 && mac_all() !== '0) bad_mac = 1'b1;
      if (res_valid === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
    e = sb.pop_front();
    n_checks++;
    if (!got) begin
      $display("FAIL %s result_timeout: no res_valid, need data %0d", nm, e.data);
      return;
    end
    if (res_data !== e.data)
      $display("FAIL %s data: got %0d need %0d", nm, res_data, e.data);
    else n_pass++;
    if (e.cyc >= 0) begin
      n_checks++;
      if (cyc != e.cyc)
        $display("FAIL %s latency: got %0d need %0d", nm, cyc - t0, e.cyc - t0);
      else n_pass++;
    end
    n_checks++;
    if (bad_ready)
      $display("FAIL %s op_ready_outside_load: got 1 need 0", nm);
    else n_pass++;
    if (cnt == 0) begin
      n_checks++;
      if (bad_mac)
        $display("FAIL %s mac_zero: got nonzero need 0", nm);
      else n_pass++;
    end
`ifdef MAC_SEQ_OVF_EN
    n_checks++;
    if (res_ovf !== e.ovf)
      $display("FAIL %s ovf: got %0b need %0b", nm, res_ovf, e.ovf);
    else n_pass++;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, op_ready, res_valid} !== 3'b000)
      $display("FAIL reset_flags: got %b need 000", {busy, op_ready, res_valid});
    else n_pass++;
    n_checks++;
    if (res_data !== 17'd0)
      $display("FAIL reset_data: got %0d need 0", res_data);
    else n_pass++;
    n_checks++;
    if (mac_all() !== '0)
      $display("FAIL reset_mac: got %h need 0", mac_all());
    else n_pass++;
`ifdef MAC_SEQ_OVF_EN
    n_checks++;
    if (res_ovf !== 1'b0)
      $display("FAIL reset_ovf: got %0b need 0", res_ovf);
    else n_pass++;
`endif
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0)
      $display("FAIL reset_idle: busy=%0b need 0", busy);
    else n_pass++;
  endtask

  task automatic test_sop();
    beat_a[0] = 8'd2; beat_b[0] = 8'd3;
    beat_a[1] = 8'd4; beat_b[1] = 8'd5;
    beat_a[2] = 8'd6; beat_b[2] = 8'd7;
    run_job(1'b0, 4'd3, 3, 0, 17'd68, 1'b0, 11, "sop");
  endtask

  task automatic test_horner();
    beat_a[0] = 8'd1; beat_b[0] = 8'd2;
    beat_a[1] = 8'd2; beat_b[1] = 8'd9;
    beat_a[2] = 8'd3; beat_b[2] = 8'd9;
    run_job(1'b1, 4'd3, 3, 0, 17'd11, 1'b0, 11, "horner");
    for (int i = 0; i < 3; i++) begin
      beat_a[i] = 8'd255; beat_b[i] = 8'd255;
    end
    run_job(1'b1, 4'd3, 3, 0, 17'd511, 1'b0, 11, "horner_wrap");
  endtask

  task automatic test_gaps();
    beat_a[0] = 8'd2; beat_b[0] = 8'd3;
    beat_a[1] = 8'd4; beat_b[1] = 8'd5;
    beat_a[2] = 8'd6; beat_b[2] = 8'd7;
    run_job(1'b0, 4'd3, 3, 2, 17'd68, 1'b0, -1, "sop_gaps");
  endtask

  task automatic test_zero();
    run_job(1'b0, 4'd0, 0, 0, 17'd0, 1'b0, 2, "zero");
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 8; i++) begin
      beat_a[i] = 8'(i + 1); beat_b[i] = 8'd1;
    end
    run_job(1'b0, 4'd15, 8, 0, 17'd36, 1'b0, 26, "clamp");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; mode = 1'b0; count = 4'd3;
    @(negedge clk);
    start = 1'b0; count = '0;
    for (int i = 0; i < 3; i++) begin
      op_valid = 1'b1; op_a = 8'(2 * i + 2); op_b = 8'(2 * i + 3);
      @(negedge clk);
    end
    op_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || mac_all() !== '0)
      $display("FAIL mid_wait: busy=%0b mac=%h need 1 and 0", busy, mac_all());
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({busy, op_ready, res_valid} !== 3'b000)
      $display("FAIL mid_reset_flags: got %b need 000", {busy, op_ready, res_valid});
    else n_pass++;
    n_checks++;
    if (res_data !== 17'd0)
      $display("FAIL mid_reset_data: got %0d need 0", res_data);
    else n_pass++;
    beat_a[0] = 8'd1; beat_b[0] = 8'd1;
    run_job(1'b0, 4'd1, 1, 0, 17'd1, 1'b0, 5, "after_reset");
  endtask

  task automatic test_ovf();
    beat_a[0] = 8'd255; beat_b[0] = 8'd255;
    beat_a[1] = 8'd255; beat_b[1] = 8'd255;
    run_job(1'b0, 4'd2, 2, 0, 17'd130050, 1'b1, 8, "ovf");
    beat_a[0] = 8'd1; beat_b[0] = 8'd1;
    run_job(1'b0, 4'd1, 1, 0, 17'd1, 1'b0, 5, "ovf_clear");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sop();
    test_horner();
    test_gaps();
    test_zero();
    test_clamp();
    test_reset_mid();
    test_ovf();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
